// File: rtl/jb_frm_mrkr_sched.sv
// Per-carrier frame-marker scheduler: 10 ms frame time base, SFN counter and
// DL/UL/PRACH marker pulses at programmed in-frame ns offsets.
module jb_frm_mrkr_sched #(
  parameter int unsigned NUM_CAR    = 2,
  parameter int unsigned NS_PER_CLK = 4,
  parameter int unsigned FRAME_NS   = 10_000_000,
  parameter int unsigned SFN_MAX    = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CAR-1:0]     frm_mrkr_gen_enable,
  input  logic [NUM_CAR-1:0]     frm_mrkr_gen_trigger,
  input  logic [NUM_CAR*32-1:0]  dl_frm_mrkr_cntr_ns,
  input  logic [NUM_CAR*32-1:0]  ul_frm_mrkr_cntr_ns,
  input  logic [NUM_CAR*32-1:0]  prach_frm_mrkr_cntr_ns,
  output logic [NUM_CAR-1:0]     dl_frm_mrkr,
  output logic [NUM_CAR-1:0]     ul_frm_mrkr,
  output logic [NUM_CAR-1:0]     prach_frm_mrkr,
  output logic [NUM_CAR*32-1:0]  frm_ns_cnt,
  output logic [NUM_CAR*10-1:0]  sfn,
  output logic [NUM_CAR-1:0]     running,
  output logic [NUM_CAR-1:0]     cfg_err
);

  // The window upper bound cnt + NS_PER_CLK must not overflow 32 bits.
  if (NS_PER_CLK < 1 || (64'(FRAME_NS) + 64'(NS_PER_CLK)) > 64'hFFFF_FFFF) begin : g_param_err
    $error("jb_frm_mrkr_sched: illegal NS_PER_CLK/FRAME_NS combination");
  end

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  logic [NUM_CAR-1:0] trig_q, trig_d;

  assign trig_d = frm_mrkr_gen_trigger;

  // Trigger history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= '0;
    else     trig_q <= trig_d;
  end

  for (genvar c = 0; c < NUM_CAR; c++) begin : g_car
    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d, nxt;
    logic [9:0]       sfn_q, sfn_d;
    logic [2:0][31:0] off_in, sh_q, sh_d;
    logic [2:0]       mrk_q, mrk_d;
    logic             err_q, err_d;
    logic             en, rise, start, latch;

    // Index 0 = DL, 1 = UL, 2 = PRACH.
    assign off_in[0] = dl_frm_mrkr_cntr_ns[c*32 +: 32];
    assign off_in[1] = ul_frm_mrkr_cntr_ns[c*32 +: 32];
    assign off_in[2] = prach_frm_mrkr_cntr_ns[c*32 +: 32];

    // Next-state: FSM, frame counter/SFN, shadow latching and marker hit detection.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sfn_d   = sfn_q;
      sh_d    = sh_q;
      err_d   = err_q;
      mrk_d   = '0;
      start   = 1'b0;
      latch   = 1'b0;
      en      = frm_mrkr_gen_enable[c];
      rise    = frm_mrkr_gen_trigger[c] & ~trig_q[c];
      nxt     = cnt_q + NS_PER_CLK;

      unique case (state_q)
        StIdle: begin
          if (en) state_d = StArmed;
        end
        StArmed: begin
          if (!en) begin
            state_d = StIdle;
          end else if (rise) begin
            state_d = StRun;
            start   = 1'b1;
          end
        end
        StRun: begin
          if (!en) begin
            state_d = StIdle;
          end else if (rise) begin
            start = 1'b1;
          end else if (nxt >= FRAME_NS) begin
            cnt_d = nxt - FRAME_NS;
            sfn_d = (sfn_q == 10'(SFN_MAX)) ? 10'd0 : sfn_q + 10'd1;
            latch = 1'b1;
          end else begin
            cnt_d = nxt;
          end
        end
        default: state_d = StIdle;
      endcase

      if (start) begin
        cnt_d = '0;
        sfn_d = '0;
        latch = 1'b1;
      end

      if (latch) begin
        sh_d = off_in;
        for (int k = 0; k < 3; k++) begin
          if (off_in[k] >= FRAME_NS) err_d = 1'b1;
        end
      end

      // Hit when the offset lies in this cycle's ns window; out-of-frame offsets never hit.
      for (int k = 0; k < 3; k++) begin
        mrk_d[k] = (state_q == StRun) && (sh_q[k] < FRAME_NS) &&
                   (sh_q[k] >= cnt_q) && (sh_q[k] < nxt);
      end
    end

    // Per-carrier state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        sfn_q   <= '0;
        sh_q    <= '0;
        mrk_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sfn_q   <= sfn_d;
        sh_q    <= sh_d;
        mrk_q   <= mrk_d;
        err_q   <= err_d;
      end
    end

    assign dl_frm_mrkr[c]         = mrk_q[0];
    assign ul_frm_mrkr[c]         = mrk_q[1];
    assign prach_frm_mrkr[c]      = mrk_q[2];
    assign frm_ns_cnt[c*32 +: 32] = cnt_q;
    assign sfn[c*10 +: 10]        = sfn_q;
    assign running[c]             = (state_q == StRun);
    assign cfg_err[c]             = err_q;
  end

endmodule

// File: tb/tb_jb_frm_mrkr_sched.sv
// Bench for jb_frm_mrkr_sched: directed scenarios followed by randomized stimulus,
// all checked against a cycle-level behavioural model of the scheduler.
module tb_jb_frm_mrkr_sched;
  localparam int unsigned NC   = 2;
  localparam int unsigned NS   = 4;
  localparam int unsigned FR   = 1000;
  localparam int unsigned SMAX = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   en, trg;
  logic [NC*32-1:0] dl_ns, ul_ns, pr_ns;
  logic [NC-1:0]   dl_mk, ul_mk, pr_mk, running, cfg_err;
  logic [NC*32-1:0] cnt;
  logic [NC*10-1:0] sfn;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: mode 0 idle, 1 armed, 2 running.
  int     m_mode [NC];
  longint m_cnt  [NC];
  int     m_frm  [NC];
  longint m_sh   [NC][3];
  bit     m_err  [NC];
  bit     m_trq  [NC];
  bit     m_mk   [NC][3];

  always #5 clk = ~clk;

  jb_frm_mrkr_sched #(
    .NUM_CAR   (NC),
    .NS_PER_CLK(NS),
    .FRAME_NS  (FR),
    .SFN_MAX   (SMAX)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .frm_mrkr_gen_enable   (en),
    .frm_mrkr_gen_trigger  (trg),
    .dl_frm_mrkr_cntr_ns   (dl_ns),
    .ul_frm_mrkr_cntr_ns   (ul_ns),
    .prach_frm_mrkr_cntr_ns(pr_ns),
    .dl_frm_mrkr           (dl_mk),
    .ul_frm_mrkr           (ul_mk),
    .prach_frm_mrkr        (pr_mk),
    .frm_ns_cnt            (cnt),
    .sfn                   (sfn),
    .running               (running),
    .cfg_err               (cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    longint o [3];
    bit     rise;
    for (int c = 0; c < NC; c++) begin
      o[0] = longint'(dl_ns[c*32 +: 32]);
      o[1] = longint'(ul_ns[c*32 +: 32]);
      o[2] = longint'(pr_ns[c*32 +: 32]);
      rise = trg[c] && !m_trq[c];
      for (int k = 0; k < 3; k++) begin
        m_mk[c][k] = !rst && m_mode[c] == 2 && m_sh[c][k] < FR &&
                     m_sh[c][k] >= m_cnt[c] && (m_sh[c][k] - m_cnt[c]) < NS;
      end
      if (rst) begin
        m_mode[c] = 0; m_cnt[c] = 0; m_frm[c] = 0; m_err[c] = 0; m_trq[c] = 0;
        for (int k = 0; k < 3; k++) m_sh[c][k] = 0;
      end else begin
        m_trq[c] = trg[c];
        if (!en[c]) begin
          m_mode[c] = 0;
        end else if (m_mode[c] == 0) begin
          m_mode[c] = 1;
        end else if (rise) begin
          m_mode[c] = 2; m_cnt[c] = 0; m_frm[c] = 0;
          for (int k = 0; k < 3; k++) begin
            m_sh[c][k] = o[k];
            if (o[k] >= FR) m_err[c] = 1;
          end
        end else if (m_mode[c] == 2) begin
          m_cnt[c] += NS;
          if (m_cnt[c] >= FR) begin
            m_cnt[c] -= FR;
            m_frm[c] = (m_frm[c] + 1) % (SMAX + 1);
            for (int k = 0; k < 3; k++) begin
              m_sh[c][k] = o[k];
              if (o[k] >= FR) m_err[c] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("dl_mk%0d", c),   64'(dl_mk[c]),          64'(m_mk[c][0]));
      chk($sformatf("ul_mk%0d", c),   64'(ul_mk[c]),          64'(m_mk[c][1]));
      chk($sformatf("pr_mk%0d", c),   64'(pr_mk[c]),          64'(m_mk[c][2]));
      chk($sformatf("cnt%0d", c),     64'(cnt[c*32 +: 32]),   64'(m_cnt[c]));
      chk($sformatf("sfn%0d", c),     64'(sfn[c*10 +: 10]),   64'(m_frm[c]));
      chk($sformatf("running%0d", c), 64'(running[c]),        64'(m_mode[c] == 2));
      chk($sformatf("cfg_err%0d", c), 64'(cfg_err[c]),        64'(m_err[c]));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = '0; trg = '0; dl_ns = '0; ul_ns = '0; pr_ns = '0;
    steps(2);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    rst = 1'b0;
    steps(1);

    // 1: car0 dl=0 ul=100 prach=998; car1 dl=40 ul=400 prach=0
    dl_ns = {32'd40, 32'd0}; ul_ns = {32'd400, 32'd100}; pr_ns = {32'd0, 32'd998};
    en = 2'b11;
    steps(1);
    trg = 2'b01;
    steps(1);                          // RUN entry edge
    chk("t1_running", 64'(running[0]), 64'd1);
    trg = 2'b00;
    steps(1);
    chk("t1_dl_first", 64'(dl_mk[0]), 64'd1);
    steps(24);
    chk("t1_ul_early", 64'(ul_mk[0]), 64'd0);
    steps(1);
    chk("t1_ul_26", 64'(ul_mk[0]), 64'd1);
    steps(223);
    chk("t1_pr_early", 64'(pr_mk[0]), 64'd0);
    steps(1);
    chk("t1_pr_250", 64'(pr_mk[0]), 64'd1);
    chk("t1_wrap_cnt", 64'(cnt[31:0]), 64'd0);
    chk("t1_wrap_sfn", 64'(sfn[9:0]), 64'd1);

    // 2: start car1, run car0 to four frames after entry
    trg = 2'b10;
    steps(1);
    trg = 2'b00;
    steps(749);
    chk("t2_sfn_wrap", 64'(sfn[9:0]), 64'd0);
    chk("t2_cnt_wrap", 64'(cnt[31:0]), 64'd0);

    // 3: ul 100 -> 500 at ns 300; takes effect next frame
    steps(75);
    chk("t3_at300", 64'(cnt[31:0]), 64'd300);
    ul_ns[31:0] = 32'd500;
    steps(301);
    chk("t3_ul_500", 64'(ul_mk[0]), 64'd1);

    // 4: out-of-frame dl offset -> sticky cfg_err
    dl_ns[31:0] = 32'd1000;
    steps(250);
    chk("t4_err", 64'(cfg_err[0]), 64'd1);
    dl_ns[31:0] = 32'd0;
    steps(300);
    chk("t4_err_sticky", 64'(cfg_err[0]), 64'd1);

    // 5: re-align at ns 600
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (cnt[31:0] == 32'd600) found = 1'b1;
      else step();
    end
    chk("t5_reach600", 64'(found), 64'd1);
    trg = 2'b01;
    steps(1);
    chk("t5_cnt0", 64'(cnt[31:0]), 64'd0);
    chk("t5_sfn0", 64'(sfn[9:0]), 64'd0);
    trg = 2'b00;
    steps(1);
    chk("t5_dl", 64'(dl_mk[0]), 64'd1);

    // 6: disable wins over trigger; car1 keeps running; then rst mid-frame
    steps(37);
    en = 2'b10; trg = 2'b01;
    steps(1);
    chk("t6_idle", 64'(running[0]), 64'd0);
    chk("t6_car1", 64'(running[1]), 64'd1);
    trg = 2'b00;
    steps(20);
    rst = 1'b1;
    steps(1);
    chk("t6_rst_cnt", 64'(cnt), 64'd0);
    chk("t6_rst_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 99) == 0) en[c] = ~en[c];
        else if ($urandom_range(0, 9) == 0) en[c] = 1'b1;
        trg[c] = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 79) == 0) dl_ns[c*32 +: 32] = $urandom_range(0, 1050);
        if ($urandom_range(0, 79) == 0) ul_ns[c*32 +: 32] = $urandom_range(0, 1050);
        if ($urandom_range(0, 79) == 0) pr_ns[c*32 +: 32] = $urandom_range(0, 1050);
      end
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
